// File: rtl/dsp_chain_4_operand_skewer.sv
// ============================================================================
// dsp_chain_4_operand_skewer: skews 4-stage fp16 operands to a DSP cascade,
// tags results and meters in-flight beats with credits.  Rev 1.0
// ============================================================================
`default_nettype none

module dsp_chain_4_operand_skewer #(
  parameter int STAGE_LAT = 1,
  parameter int RES_LAT   = 2,
  parameter int MAX_OUT   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [255:0]                     in_ops,
  input  logic                             in_last,
  output logic [255:0]                     out_ops,
  output logic                             res_valid,
  output logic                             res_last,
  input  logic                             res_ack,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
  output logic                             err_underflow
);

  localparam int CW        = $clog2(MAX_OUT + 1);
  localparam int TAG_DEPTH = 1 + 3 * STAGE_LAT + RES_LAT;
  localparam logic [CW-1:0] C_MAX_OUT = CW'(MAX_OUT);

  logic accept;
  assign accept = in_valid & in_ready;

  // Operand lanes: stage k sits behind k*STAGE_LAT extra registers
  for (genvar k = 0; k < 4; k++) begin : g_stage
    localparam int DEPTH = 1 + k * STAGE_LAT;
    logic [DEPTH-1:0][63:0] lane_q;
    logic [DEPTH-1:0][63:0] lane_d;

    always_comb begin
      lane_d    = lane_q;
      lane_d[0] = accept ? in_ops[64*k +: 64] : 64'h0;
      for (int i = 1; i < DEPTH; i++) begin
        lane_d[i] = lane_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign out_ops[64*k +: 64] = lane_q[DEPTH-1];
  end

  // {valid, last} tags travel alongside the partial sum to the final result
  logic [TAG_DEPTH-1:0][1:0] tag_q;
  logic [TAG_DEPTH-1:0][1:0] tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = accept ? {1'b1, in_last} : 2'b00;
    for (int i = 1; i < TAG_DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign res_valid = tag_q[TAG_DEPTH-1][1];
  assign res_last  = tag_q[TAG_DEPTH-1][0];

  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;
  logic          err_underflow_q;
  logic          err_underflow_d;
  logic          ack_ok;

  // An ack with nothing outstanding is dropped and latched as an error
  always_comb begin
    ack_ok          = res_ack && (outstanding_q != '0);
    outstanding_d   = outstanding_q;
    err_underflow_d = err_underflow_q | (res_ack && (outstanding_q == '0));
    if (accept && !ack_ok) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!accept && ack_ok) begin
      outstanding_d = outstanding_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign in_ready      = (outstanding_q < C_MAX_OUT);
  assign outstanding   = outstanding_q;
  assign err_underflow = err_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_chain_4_operand_skewer.sv
// ============================================================================
// tb_dsp_chain_4_operand_skewer: directed self-checking bench for the skewer,
// default latencies plus a STAGE_LAT=2 / RES_LAT=3 instance.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dsp_chain_4_operand_skewer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_last, res_ack;
  logic [255:0] in_ops;
  logic         in_ready, res_valid, res_last, err_underflow;
  logic [255:0] out_ops;
  logic [3:0]   outstanding;

  logic         b_in_valid, b_in_last, b_res_ack;
  logic [255:0] b_in_ops;
  logic         b_in_ready, b_res_valid, b_res_last, b_err_underflow;
  logic [255:0] b_out_ops;
  logic [3:0]   b_outstanding;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_chain_4_operand_skewer #(.STAGE_LAT(1), .RES_LAT(2), .MAX_OUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ops(in_ops), .in_last(in_last), .out_ops(out_ops),
    .res_valid(res_valid), .res_last(res_last), .res_ack(res_ack),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  dsp_chain_4_operand_skewer #(.STAGE_LAT(2), .RES_LAT(3), .MAX_OUT(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ops(b_in_ops), .in_last(b_in_last), .out_ops(b_out_ops),
    .res_valid(b_res_valid), .res_last(b_res_last), .res_ack(b_res_ack),
    .outstanding(b_outstanding), .err_underflow(b_err_underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_ops   = {16{16'h1234}};
    repeat (3) step();
    total++; if (out_ops !== 256'h0) begin bad++; $display("FAIL reset_out_ops got=%h exp=0", out_ops); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ops   = '0;
    reset    = 1'b1;
    step();
  endtask

  task automatic test_single_beat();
    logic [63:0] slice;
    logic [63:0] exp_s;
    slice    = {16'h4000, 16'h4000, 16'h3C00, 16'h3C00};
    in_ops   = {4{slice}};
    in_last  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ops   = '0;
    for (int n = 1; n <= 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        exp_s = (n == 1 + k) ? slice : 64'h0;
        total++;
        if (out_ops[64*k +: 64] !== exp_s) begin
          bad++; $display("FAIL single_stage%0d cyc=%0d got=%h exp=%h", k, n, out_ops[64*k +: 64], exp_s);
        end
      end
      total++; if (res_valid !== (n == 6)) begin bad++; $display("FAIL single_res_valid cyc=%0d got=%b exp=%b", n, res_valid, (n == 6)); end
      total++; if (res_last !== (n == 6)) begin bad++; $display("FAIL single_res_last cyc=%0d got=%b exp=%b", n, res_last, (n == 6)); end
      total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL single_outstanding cyc=%0d got=%0d exp=1", n, outstanding); end
      step();
    end
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL single_ack got=%0d exp=0", outstanding); end
  endtask

  task automatic test_streaming();
    int acc;
    logic [63:0] exp0, exp3;
    logic [15:0] v;
    acc = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n <= 10) begin
        v        = 16'(n);
        in_valid = 1'b1;
        in_ops   = {16{v}};
        in_last  = (n == 10);
        total++;
        if (in_ready !== (n <= 8)) begin bad++; $display("FAIL stream_in_ready beat=%0d got=%b exp=%b", n, in_ready, (n <= 8)); end
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
        in_ops   = '0;
        in_last  = 1'b0;
      end
      step();
      v    = 16'(n);
      exp0 = (n <= 8) ? {4{v}} : 64'h0;
      v    = 16'(n - 3);
      exp3 = (n >= 4 && n <= 11) ? {4{v}} : 64'h0;
      total++; if (out_ops[63:0] !== exp0) begin bad++; $display("FAIL stream_stage0 cyc=%0d got=%h exp=%h", n, out_ops[63:0], exp0); end
      total++; if (out_ops[255:192] !== exp3) begin bad++; $display("FAIL stream_stage3 cyc=%0d got=%h exp=%h", n, out_ops[255:192], exp3); end
      total++; if (res_valid !== (n >= 6 && n <= 13)) begin bad++; $display("FAIL stream_res_valid cyc=%0d got=%b exp=%b", n, res_valid, (n >= 6 && n <= 13)); end
      total++; if (res_last !== 1'b0) begin bad++; $display("FAIL stream_res_last cyc=%0d got=%b exp=0", n, res_last); end
      total++; if (outstanding !== 4'((n < 8) ? n : 8)) begin bad++; $display("FAIL stream_outstanding cyc=%0d got=%0d exp=%0d", n, outstanding, (n < 8) ? n : 8); end
    end
    total++; if (acc != 8) begin bad++; $display("FAIL stream_accepts got=%0d exp=8", acc); end
  endtask

  task automatic test_simultaneous();
    in_ops   = {16{16'h00AA}};
    in_valid = 1'b1;
    res_ack  = 1'b1;
    step();
    total++; if (outstanding !== 4'd7) begin bad++; $display("FAIL simul_ack_only got=%0d exp=7", outstanding); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL simul_ready_rise got=%b exp=1", in_ready); end
    step();
    total++; if (outstanding !== 4'd7) begin bad++; $display("FAIL simul_ack_and_accept got=%0d exp=7", outstanding); end
    res_ack = 1'b0;
    step();
    in_valid = 1'b0;
    total++; if (outstanding !== 4'd8) begin bad++; $display("FAIL simul_accept_only got=%0d exp=8", outstanding); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL simul_ready_fall got=%b exp=0", in_ready); end
    res_ack = 1'b1;
    repeat (8) step();
    res_ack = 1'b0;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL simul_drain got=%0d exp=0", outstanding); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL simul_no_underflow got=%b exp=0", err_underflow); end
    repeat (10) step();
  endtask

  task automatic test_underflow();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b exp=1", err_underflow); end
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", outstanding); end
    repeat (20) step();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
    reset = 1'b0;
    #1;
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL underflow_clear got=%b exp=0", err_underflow); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_midflight_reset();
    int pulses;
    pulses   = 0;
    in_ops   = {16{16'h7E00}};
    in_last  = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ops   = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL midrst_outstanding got=%0d exp=0", outstanding); end
    total++; if (out_ops !== 256'h0) begin bad++; $display("FAIL midrst_out_ops got=%h exp=0", out_ops); end
    step();
    reset = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (res_valid) pulses++;
      step();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_res_valid pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_param_sweep();
    logic [63:0] slice;
    logic [63:0] exp_s;
    slice      = {16'h4000, 16'h4000, 16'h3C00, 16'h3C00};
    b_in_ops   = {4{slice}};
    b_in_last  = 1'b1;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    b_in_ops   = '0;
    for (int n = 1; n <= 12; n++) begin
      for (int k = 0; k < 4; k++) begin
        exp_s = (n == 1 + 2 * k) ? slice : 64'h0;
        total++;
        if (b_out_ops[64*k +: 64] !== exp_s) begin
          bad++; $display("FAIL sweep_stage%0d cyc=%0d got=%h exp=%h", k, n, b_out_ops[64*k +: 64], exp_s);
        end
      end
      total++; if (b_res_valid !== (n == 10)) begin bad++; $display("FAIL sweep_res_valid cyc=%0d got=%b exp=%b", n, b_res_valid, (n == 10)); end
      total++; if (b_res_last !== (n == 10)) begin bad++; $display("FAIL sweep_res_last cyc=%0d got=%b exp=%b", n, b_res_last, (n == 10)); end
      step();
    end
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_ops     = '0;
    res_ack    = 1'b0;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    b_in_ops   = '0;
    b_res_ack  = 1'b0;
    test_reset();
    test_single_beat();
    test_streaming();
    test_simultaneous();
    test_underflow();
    test_midflight_reset();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
